// File: rtl/apb_fifo_pkg.sv
// ============================================================================
// Module      : apb_fifo_pkg
// Description : Shared register offsets, FSM states and register bit positions
//               for the APB FIFO completer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_fifo_pkg;

    // Register offsets decoded from PADDR[3:0]
    localparam logic [3:0] c_OFF_DATA   = 4'h0;
    localparam logic [3:0] c_OFF_STATUS = 4'h4;
    localparam logic [3:0] c_OFF_CTRL   = 4'h8;

    // STATUS register layout
    localparam int c_ST_TX_FULL    = 0;
    localparam int c_ST_TX_EMPTY   = 1;
    localparam int c_ST_RX_FULL    = 2;
    localparam int c_ST_RX_EMPTY   = 3;
    localparam int c_ST_TX_CNT_LSB = 8;
    localparam int c_ST_RX_CNT_LSB = 16;
    localparam int c_ST_CNT_W      = 8;

    // CTRL register layout; all live bits sit in byte 0
    localparam int c_CTRL_TX_FLUSH = 0;
    localparam int c_CTRL_RX_FLUSH = 1;
    localparam int c_CTRL_STALL_EN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_t;

    function automatic logic is_known_offset(input logic [3:0] off);
        return (off == c_OFF_DATA) || (off == c_OFF_STATUS) || (off == c_OFF_CTRL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_sync_fifo.sv
// ============================================================================
// Module      : apb_sync_fifo
// Description : Single-clock FIFO with occupancy count and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/apb_fifo_completer.sv
// ============================================================================
// Module      : apb_fifo_completer
// Description : APB completer moving words through a TX FIFO (APB -> stream)
//               and an RX FIFO (stream -> APB), with wait states and timeout.
//               Optional APB_PSTRB_EN adds byte strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_fifo_completer
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] PRDATA,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data
);

    localparam int c_CNT_W  = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int c_FCNT_W = $clog2(DEPTH) + 1;

    apb_state_t          r_state;
    apb_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic [c_CNT_W-1:0]  w_wait_cnt_nxt;
    logic                w_goto_resp;
    logic                w_err;
    logic                w_do_access;

    logic                r_pready;
    logic                r_pslverr;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_stall_en;
    logic                r_tx_flush;
    logic                r_rx_flush;

    logic [3:0]          w_off;
    logic                w_is_data;
    logic                w_is_status;
    logic                w_is_ctrl;
    logic                w_bad;
    logic                w_can;
    logic                w_strb_full;
    logic                w_ctrl_b0;
    logic                w_tx_push;
    logic                w_rx_pop;
    logic                w_ctrl_wr;
    logic [DATA_W-1:0]   w_status;
    logic [DATA_W-1:0]   w_rdata;

    logic                w_tx_full;
    logic                w_tx_empty;
    logic [c_FCNT_W-1:0] w_tx_count;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic [c_FCNT_W-1:0] w_rx_count;
    logic [DATA_W-1:0]   w_rx_head;
    logic                w_unused_addr;

    assign w_unused_addr = ^PADDR[ADDR_W-1:4];

`ifdef APB_PSTRB_EN
    assign w_strb_full = &PSTRB;
    assign w_ctrl_b0   = PSTRB[0];
`else
    assign w_strb_full = 1'b1;
    assign w_ctrl_b0   = 1'b1;
`endif

    assign w_off       = PADDR[3:0];
    assign w_is_data   = (w_off == c_OFF_DATA);
    assign w_is_status = (w_off == c_OFF_STATUS);
    assign w_is_ctrl   = (w_off == c_OFF_CTRL);
    assign w_bad       = !is_known_offset(w_off)
                       || (w_is_status && PWRITE)
                       || (w_is_data && PWRITE && !w_strb_full);
    // Flags come from the current count, so a same-cycle stream pop does not help
    assign w_can       = !w_is_data || (PWRITE ? !w_tx_full : !w_rx_empty);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_goto_resp    = 1'b0;
        w_err          = 1'b0;
        w_do_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt    = ST_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bad) begin
                    w_state_nxt = ST_RESP;
                    w_goto_resp = 1'b1;
                    w_err       = 1'b1;
                end else if (w_can) begin
                    w_state_nxt = ST_RESP;
                    w_goto_resp = 1'b1;
                    w_do_access = 1'b1;
                end else if (!r_stall_en || (r_wait_cnt == c_CNT_W'(WAIT_MAX))) begin
                    w_state_nxt = ST_RESP;
                    w_goto_resp = 1'b1;
                    w_err       = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_tx_push = w_do_access && w_is_data && PWRITE;
    assign w_rx_pop  = w_do_access && w_is_data && !PWRITE;
    assign w_ctrl_wr = w_do_access && w_is_ctrl && PWRITE && w_ctrl_b0;

    always_comb begin
        w_status                                  = '0;
        w_status[c_ST_TX_FULL]                    = w_tx_full;
        w_status[c_ST_TX_EMPTY]                   = w_tx_empty;
        w_status[c_ST_RX_FULL]                    = w_rx_full;
        w_status[c_ST_RX_EMPTY]                   = w_rx_empty;
        w_status[c_ST_TX_CNT_LSB +: c_ST_CNT_W]   = c_ST_CNT_W'(w_tx_count);
        w_status[c_ST_RX_CNT_LSB +: c_ST_CNT_W]   = c_ST_CNT_W'(w_rx_count);
    end

    always_comb begin
        w_rdata = '0;
        if (!PWRITE) begin
            if (w_is_data)        w_rdata = w_rx_head;
            else if (w_is_status) w_rdata = w_status;
            else if (w_is_ctrl)   w_rdata[c_CTRL_STALL_EN] = r_stall_en;
        end
    end

    // Flush pulses are held for the RESP cycle so the FIFO reads empty afterwards
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_stall_en <= 1'b0;
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
        end else begin
            r_pready   <= w_goto_resp;
            r_pslverr  <= w_goto_resp && w_err;
            r_prdata   <= (w_goto_resp && !w_err) ? w_rdata : '0;
            r_tx_flush <= w_ctrl_wr && PWDATA[c_CTRL_TX_FLUSH];
            r_rx_flush <= w_ctrl_wr && PWDATA[c_CTRL_RX_FLUSH];
            if (w_ctrl_wr) r_stall_en <= PWDATA[c_CTRL_STALL_EN];
        end
    end

    assign PREADY   = r_pready;
    assign PSLVERR  = r_pslverr;
    assign PRDATA   = r_prdata;
    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;

    apb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (w_tx_push),
        .i_wdata (PWDATA),
        .i_pop   (tx_ready),
        .i_flush (r_tx_flush),
        .o_rdata (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    apb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (rx_valid),
        .i_wdata (rx_data),
        .i_pop   (w_rx_pop),
        .i_flush (r_rx_flush),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_fifo_completer.sv
// ============================================================================
// Module      : tb_apb_fifo_completer
// Description : Directed scoreboard bench for the APB FIFO completer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_fifo_completer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] rx_data = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic        snap_tx_valid;
    logic [31:0] snap_tx_data;
    int          cyc;

    apb_fifo_completer dut (
        .PCLK     (clk),
        .PRESET   (rst),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PADDR    (paddr),
        .PWDATA   (pwdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr),
        .PRDATA   (prdata),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed transfer is checked against the queue head
    always @(negedge clk) begin
        if (!rst && pready) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got PREADY with pslverr=%0b prdata=0x%08h, expected no response",
                         pslverr, prdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (pslverr !== e.err || prdata !== e.data) begin
                    fails++;
                    $display("FAIL sb_resp: got pslverr=%0b prdata=0x%08h expected pslverr=%0b prdata=0x%08h",
                             pslverr, prdata, e.err, e.data);
                end
            end
        end
    end

    // Called and returns at posedge+1; cycles counts access-phase cycles incl. the PREADY one
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_data, output int cycles);
        exp_t e;
        logic done;
        e.err  = exp_err;
        e.data = exp_data;
        sb_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (pready) begin
                done = 1'b1;
                snap_tx_valid = tx_valid;
                snap_tx_data  = tx_data;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL apb_timeout: got no PREADY within 40 cycles, expected a response");
            void'(sb_q.pop_back());
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  {31'd0, pready},   32'd0);
        check("rst_pslverr", {31'd0, pslverr},  32'd0);
        check("rst_prdata",  prdata,            32'd0);
        check("rst_txvalid", {31'd0, tx_valid}, 32'd0);
        check("rst_rxready", {31'd0, rx_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_000A, cyc);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, 32'h0, cyc);

        // 1: single write, minimum latency, stream sees word next cycle
        tx_ready = 1'b1;
        apb_xfer(1'b1, 32'h0, 32'hCAFE_0001, 1'b0, 32'h0, cyc);
        check("t1_cycles",  cyc, 32'd2);
        check("t1_txvalid", {31'd0, snap_tx_valid}, 32'd1);
        check("t1_txdata",  snap_tx_data, 32'hCAFE_0001);

        // 2: rx stream fills two words, APB reads drain in order
        rx_valid = 1'b1; rx_data = 32'h11;
        @(posedge clk); #1;
        rx_data = 32'h22;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        apb_xfer(1'b0, 32'h0, 32'h0, 1'b0, 32'h11, cyc);
        apb_xfer(1'b0, 32'h0, 32'h0, 1'b0, 32'h22, cyc);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_000A, cyc);

        // 3: stall enabled, fill TX, ninth write times out
        apb_xfer(1'b1, 32'h8, 32'h4, 1'b0, 32'h0, cyc);
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) apb_xfer(1'b1, 32'h0, 32'h100 + i, 1'b0, 32'h0, cyc);
        apb_xfer(1'b1, 32'h0, 32'h1FF, 1'b1, 32'h0, cyc);
        check("t3_timeout_cycles", cyc, 32'd17);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0809, cyc);
        apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, 32'h0000_0004, cyc);

        // 4: ninth write with one stream pop at wait cycle 5
        fork
            apb_xfer(1'b1, 32'h0, 32'h200, 1'b0, 32'h0, cyc);
            begin
                repeat (6) @(posedge clk);
                #1 tx_ready = 1'b1;
                @(posedge clk);
                #1 tx_ready = 1'b0;
            end
        join
        check("t4_cycles", cyc, 32'd8);
        check("t4_txhead", tx_data, 32'h101);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0809, cyc);

        // 5: bad accesses, then TX flush
        apb_xfer(1'b0, 32'hC, 32'h0, 1'b1, 32'h0, cyc);
        apb_xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b1, 32'h0, cyc);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0809, cyc);
        apb_xfer(1'b1, 32'h8, 32'h1, 1'b0, 32'h0, cyc);
        check("t5_txvalid", {31'd0, tx_valid}, 32'd0);
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_000A, cyc);
        apb_xfer(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, cyc);
        check("t5_nostall_cycles", cyc, 32'd2);

        // 6: reset while a read is stalled in WAIT
        apb_xfer(1'b1, 32'h8, 32'h4, 1'b0, 32'h0, cyc);
        apb_xfer(1'b1, 32'h0, 32'h77, 1'b0, 32'h0, cyc);
        check("t6_pre_txvalid", {31'd0, tx_valid}, 32'd1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_pready",  {31'd0, pready},   32'd0);
        check("t6_txvalid", {31'd0, tx_valid}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rxready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_000A, cyc);
        apb_xfer(1'b1, 32'h0, 32'h55, 1'b0, 32'h0, cyc);
        check("t6_cycles",  cyc, 32'd2);
        check("t6_txdata",  snap_tx_data, 32'h55);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
